// File: rtl/fifo_sync_flags_if.sv
// rtl/fifo_sync_flags_if.sv - write/read handshake and status bundle for fifo_sync_flags
interface fifo_sync_flags_if #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 7
);
  logic                   clr;
  logic                   wr_en;
  logic [DATA_WIDTH-1:0]  din;
  logic                   rd_en;
  logic [DATA_WIDTH-1:0]  dout;
  logic                   empty;
  logic                   full;
  logic                   almost_empty;
  logic                   almost_full;
  logic [ADDRESS_WIDTH:0] data_count;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output clr, wr_en, din, rd_en,
    input  dout, empty, full, almost_empty, almost_full, data_count, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, din, rd_en,
    output dout, empty, full, almost_empty, almost_full, data_count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_flags.sv
// rtl/fifo_sync_flags.sv - single-clock FIFO with FWFT/standard read, count, threshold and error flags
module fifo_sync_flags #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 7,
  parameter bit FWFT          = 1'b1,
  parameter int AFULL_THRESH  = (2 ** ADDRESS_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input logic              clk,
  input logic              rst,
  fifo_sync_flags_if.slave bus
);
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  typedef logic [ADDRESS_WIDTH-1:0] ptr_t;
  typedef logic [ADDRESS_WIDTH:0]   cnt_t;
  typedef logic [DATA_WIDTH-1:0]    word_t;

  localparam cnt_t DEPTH_C  = cnt_t'(DEPTH);
  localparam cnt_t AFULL_C  = cnt_t'(AFULL_THRESH);
  localparam cnt_t AEMPTY_C = cnt_t'(AEMPTY_THRESH);

  if (ADDRESS_WIDTH < 1) begin : g_bad_address_width
    $error("fifo_sync_flags: ADDRESS_WIDTH must be at least 1");
  end
  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $error("fifo_sync_flags: DATA_WIDTH must be at least 1");
  end
  if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_afull
    $error("fifo_sync_flags: AFULL_THRESH must lie in 1..DEPTH");
  end
  if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH > DEPTH - 1)) begin : g_bad_aempty
    $error("fifo_sync_flags: AEMPTY_THRESH must lie in 0..DEPTH-1");
  end

  word_t mem [DEPTH];

  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  rd_ptr_q, rd_ptr_d;
  cnt_t  count_q, count_d;
  word_t dout_q, dout_d;
  logic  valid_q, valid_d;
  logic  empty_q, empty_d;
  logic  full_q, full_d;
  logic  aempty_q, aempty_d;
  logic  afull_q, afull_d;
  logic  ovf_q, ovf_d;
  logic  udf_q, udf_d;
  logic  wr_acc, rd_acc;

  // Words stay in RAM until popped, so data_count naturally includes the
  // FWFT output register; valid_q marks whether dout already shows the head.
  always_comb begin
    wr_acc   = bus.wr_en && !full_q;
    rd_acc   = bus.rd_en && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    valid_d  = valid_q;
    ovf_d    = bus.wr_en && full_q;
    udf_d    = bus.rd_en && empty_q;

    if (bus.clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      dout_d   = '0;
      valid_d  = 1'b0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + ptr_t'(1);
      if (wr_acc && !rd_acc) begin
        count_d = count_q + cnt_t'(1);
      end else if (rd_acc && !wr_acc) begin
        count_d = count_q - cnt_t'(1);
      end

      if (FWFT) begin
        if (rd_acc) begin
          if (count_q > cnt_t'(1)) begin
            dout_d  = mem[rd_ptr_d];
            valid_d = 1'b1;
          end else if (wr_acc) begin
            // Only word is leaving while a new one arrives: bypass the RAM.
            dout_d  = bus.din;
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
        end else if (!valid_q && (count_q != '0)) begin
          dout_d  = mem[rd_ptr_q];
          valid_d = 1'b1;
        end
      end else begin
        if (rd_acc) dout_d = mem[rd_ptr_q];
        valid_d = (count_d != '0);
      end
    end

    empty_d  = !valid_d;
    full_d   = (count_d == DEPTH_C);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !bus.clr) mem[wr_ptr_q] <= bus.din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      aempty_q <= aempty_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign bus.dout         = dout_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = aempty_q;
  assign bus.almost_full  = afull_q;
  assign bus.data_count   = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb/tb_fifo_sync_flags.sv - vector table, directed corners and random traffic for fifo_sync_flags
module tb_fifo_sync_flags;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFT   = 12;
  localparam int AET   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_sync_flags_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) st_if ();
  fifo_sync_flags_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) fw_if ();

  fifo_sync_flags #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FWFT(1'b0),
                    .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET))
    u_std (.clk(clk), .rst(rst), .bus(st_if));

  fifo_sync_flags #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FWFT(1'b1),
                    .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET))
    u_fwft (.clk(clk), .rst(rst), .bus(fw_if));

  int n_tests = 0;
  int n_fail  = 0;
  bit sel     = 1'b0;

  logic [DW-1:0] a_dout;
  logic [AW:0]   a_count;
  logic          a_empty, a_full, a_ae, a_af, a_ovf, a_udf;
  assign a_dout  = sel ? fw_if.dout         : st_if.dout;
  assign a_count = sel ? fw_if.data_count   : st_if.data_count;
  assign a_empty = sel ? fw_if.empty        : st_if.empty;
  assign a_full  = sel ? fw_if.full         : st_if.full;
  assign a_ae    = sel ? fw_if.almost_empty : st_if.almost_empty;
  assign a_af    = sel ? fw_if.almost_full  : st_if.almost_full;
  assign a_ovf   = sel ? fw_if.overflow     : st_if.overflow;
  assign a_udf   = sel ? fw_if.underflow    : st_if.underflow;

  bit            c_clr, c_wr, c_rd;
  logic [DW-1:0] c_din;

  logic [DW-1:0] mq [$];
  int            me [$];
  int            m_edge = 0;
  bit            m_vis;
  logic [DW-1:0] m_dout;
  bit            m_ovf, m_udf;

  typedef struct {
    bit            clr, wr, rd;
    logic [DW-1:0] din;
    int            cnt;
    bit            emp, ful, af, ae, ovf, udf;
    logic [DW-1:0] dout;
  } vec_t;
  vec_t vt [35];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit c, input bit w, input bit r, input logic [DW-1:0] d);
    c_clr = c; c_wr = w; c_rd = r; c_din = d;
    st_if.clr   = !sel && c;
    st_if.wr_en = !sel && w;
    st_if.rd_en = !sel && r;
    st_if.din   = d;
    fw_if.clr   = sel && c;
    fw_if.wr_en = sel && w;
    fw_if.rd_en = sel && r;
    fw_if.din   = d;
  endtask

  task automatic model_clear();
    mq.delete();
    me.delete();
    m_vis  = 1'b0;
    m_dout = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  // Reference: a plain queue of words, each tagged with the edge it arrived on.
  // FWFT shows the head once it arrived on an earlier edge or right after a pop.
  task automatic model_edge();
    bit emp, ful, wa, ra;
    m_edge++;
    if (c_clr) begin
      model_clear();
      return;
    end
    emp   = sel ? !m_vis : (mq.size() == 0);
    ful   = (mq.size() == DEPTH);
    wa    = c_wr && !ful;
    ra    = c_rd && !emp;
    m_ovf = c_wr && ful;
    m_udf = c_rd && emp;
    if (ra) begin
      if (!sel) m_dout = mq[0];
      void'(mq.pop_front());
      void'(me.pop_front());
    end
    if (wa) begin
      mq.push_back(c_din);
      me.push_back(m_edge);
    end
    if (sel) begin
      m_vis = 1'b0;
      if (mq.size() > 0) m_vis = ra || (me[0] < m_edge);
      if (m_vis) m_dout = mq[0];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic check_model(input string name);
    bit exp_empty;
    exp_empty = sel ? !m_vis : (mq.size() == 0);
    chk({name, " count"}, 64'(a_count), 64'(mq.size()));
    chk({name, " empty"}, 64'(a_empty), 64'(exp_empty));
    chk({name, " full"},  64'(a_full),  64'(mq.size() == DEPTH));
    chk({name, " afull"}, 64'(a_af),    64'(mq.size() >= AFT));
    chk({name, " aempty"},64'(a_ae),    64'(mq.size() <= AET));
    chk({name, " ovf"},   64'(a_ovf),   64'(m_ovf));
    chk({name, " udf"},   64'(a_udf),   64'(m_udf));
    if (!exp_empty || !sel) chk({name, " dout"}, 64'(a_dout), 64'(m_dout));
  endtask

  task automatic check_reset(input string name);
    chk({name, " rst count"},  64'(a_count), 64'(0));
    chk({name, " rst empty"},  64'(a_empty), 64'(1));
    chk({name, " rst full"},   64'(a_full),  64'(0));
    chk({name, " rst aempty"}, 64'(a_ae),    64'(1));
    chk({name, " rst afull"},  64'(a_af),    64'(0));
    chk({name, " rst ovf"},    64'(a_ovf),   64'(0));
    chk({name, " rst udf"},    64'(a_udf),   64'(0));
    chk({name, " rst dout"},   64'(a_dout),  64'(0));
  endtask

  task automatic random_run(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 6,
            $urandom_range(0, 9) < 5, DW'($urandom));
      step();
      check_model($sformatf("%s rnd%0d", name, i));
    end
  endtask

  // Called just after a clock edge: reset lands mid-cycle, is checked before
  // the next edge, and is released well away from any edge.
  task automatic async_reset_check(input string name);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, i[0], DW'(16'h0700 + i));
      step();
    end
    #3 rst = 1'b1;
    #1 check_reset({name, " async"});
    drive(1'b0, 1'b0, 1'b0, '0);
    #1 rst = 1'b0;
    model_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int guard;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    sel = 1'b0; #1 check_reset("std");
    sel = 1'b1; #1 check_reset("fwft");
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++)
      vt[i] = '{1'b0, 1'b1, 1'b0, DW'(i + 1), i + 1, 1'b0, i == 15,
                (i + 1) >= AFT, (i + 1) <= AET, 1'b0, 1'b0, '0};
    vt[16] = '{1'b0, 1'b1, 1'b0, 16'h00AA, 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '0};
    for (int i = 0; i < 16; i++)
      vt[17 + i] = '{1'b0, 1'b0, 1'b1, '0, 15 - i, i == 15, 1'b0,
                     (15 - i) >= AFT, (15 - i) <= AET, 1'b0, 1'b0, DW'(i + 1)};
    vt[33] = '{1'b0, 1'b0, 1'b1, '0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0010};
    vt[34] = '{1'b0, 1'b0, 1'b0, '0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010};

    for (int i = 0; i < 35; i++) begin
      drive(vt[i].clr, vt[i].wr, vt[i].rd, vt[i].din);
      step();
      chk($sformatf("vec%0d count", i),  64'(a_count), 64'(vt[i].cnt));
      chk($sformatf("vec%0d empty", i),  64'(a_empty), 64'(vt[i].emp));
      chk($sformatf("vec%0d full", i),   64'(a_full),  64'(vt[i].ful));
      chk($sformatf("vec%0d afull", i),  64'(a_af),    64'(vt[i].af));
      chk($sformatf("vec%0d aempty", i), 64'(a_ae),    64'(vt[i].ae));
      chk($sformatf("vec%0d ovf", i),    64'(a_ovf),   64'(vt[i].ovf));
      chk($sformatf("vec%0d udf", i),    64'(a_udf),   64'(vt[i].udf));
      chk($sformatf("vec%0d dout", i),   64'(a_dout),  64'(vt[i].dout));
    end

    random_run("std", 300);
    async_reset_check("std");

    sel = 1'b1;
    #1;
    drive(1'b0, 1'b1, 1'b0, 16'h0055);
    step();
    chk("fwft lat empty t", 64'(a_empty), 64'(1));
    chk("fwft lat count t", 64'(a_count), 64'(1));
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    chk("fwft lat empty t1", 64'(a_empty), 64'(0));
    chk("fwft lat dout t1",  64'(a_dout),  64'(16'h0055));
    drive(1'b0, 1'b0, 1'b1, '0);
    step();
    chk("fwft pop empty", 64'(a_empty), 64'(1));
    chk("fwft pop count", 64'(a_count), 64'(0));

    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, DW'(16'h0100 + i));
      step();
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    for (int k = 0; k < 40; k++) begin
      drive(1'b0, 1'b1, 1'b1, DW'(16'h0105 + k));
      step();
      chk($sformatf("stream%0d count", k), 64'(a_count), 64'(5));
      chk($sformatf("stream%0d dout", k),  64'(a_dout),  64'(16'h0101 + k));
      chk($sformatf("stream%0d flags", k),
          64'({a_empty, a_full, a_af, a_ae, a_ovf, a_udf}), 64'(0));
    end

    drive(1'b1, 1'b0, 1'b0, '0);
    step();
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, 1'b0, DW'(16'h0200 + i));
      step();
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    chk("flush pre count", 64'(a_count), 64'(9));
    drive(1'b1, 1'b1, 1'b1, 16'h0EEE);
    step();
    chk("flush count", 64'(a_count), 64'(0));
    chk("flush empty", 64'(a_empty), 64'(1));
    chk("flush dout",  64'(a_dout),  64'(0));
    chk("flush pulses", 64'({a_ovf, a_udf}), 64'(0));
    drive(1'b0, 1'b1, 1'b0, 16'h0300); step();
    drive(1'b0, 1'b1, 1'b0, 16'h0301); step();
    drive(1'b0, 1'b0, 1'b0, '0);       step();
    chk("post flush head", 64'(a_dout), 64'(16'h0300));
    drive(1'b0, 1'b0, 1'b1, '0);       step();
    chk("post flush next", 64'(a_dout), 64'(16'h0301));
    check_model("post flush");

    guard = 0;
    while (mq.size() < DEPTH && guard < 40) begin
      drive(1'b0, 1'b1, 1'b0, DW'(16'h0400 + guard));
      step();
      guard++;
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    chk("bound full", 64'(a_full), 64'(1));
    drive(1'b0, 1'b1, 1'b1, 16'h0BAD);
    step();
    chk("bound full both count", 64'(a_count), 64'(15));
    chk("bound full both ovf",   64'(a_ovf),   64'(1));
    chk("bound full both udf",   64'(a_udf),   64'(0));
    check_model("bound full both");
    guard = 0;
    while (mq.size() > 0 && guard < 40) begin
      drive(1'b0, 1'b0, 1'b1, '0);
      step();
      guard++;
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    chk("bound drained empty", 64'(a_empty), 64'(1));
    drive(1'b0, 1'b1, 1'b1, 16'h0600);
    step();
    chk("bound empty both count", 64'(a_count), 64'(1));
    chk("bound empty both udf",   64'(a_udf),   64'(1));
    chk("bound empty both ovf",   64'(a_ovf),   64'(0));
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    chk("bound empty both dout", 64'(a_dout), 64'(16'h0600));
    check_model("bound empty both");

    random_run("fwft", 300);
    async_reset_check("fwft");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
Parametrised single-clock FIFO, the successor to the fixed-width PCIe-config packet FIFO wrapper. It adds configurable data width and depth, a selectable first-word-fall-through (FWFT) or standard read mode, occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow pulses, and synchronous flush. It buffers TLP/config records between the PCIe endpoint side and the Ethernet encapsulation logic. Storage is inferred RAM plus pointer/flag control; no vendor IP.

Parameters:
DATA_WIDTH, 64, bits per word
ADDRESS_WIDTH, 7, DEPTH = 2**ADDRESS_WIDTH words total capacity, in both modes
FWFT, 1, 1 = first-word-fall-through; 0 = standard registered read
AFULL_THRESH, DEPTH-4, almost_full asserted when data_count >= AFULL_THRESH
AEMPTY_THRESH, 4, almost_empty asserted when data_count <= AEMPTY_THRESH

Ports:
clk  input  1  single clock for all logic
rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous flush, active-high
wr_en  input  1  write request
din  input  DATA_WIDTH  write data
rd_en  input  1  read request (FWFT: pop/acknowledge; standard: fetch)
dout  output  DATA_WIDTH  read data
empty  output  1  no readable word (FWFT: dout is invalid)
full  output  1  DEPTH words held
almost_empty  output  1  threshold flag
almost_full  output  1  threshold flag
data_count  output  ADDRESS_WIDTH+1  words held, 0..DEPTH
overflow  output  1  one-cycle pulse: a write was rejected
underflow  output  1  one-cycle pulse: a read was rejected

Behaviour:
- Reset (async assert, release synchronous to clk): pointers=0, data_count=0, dout=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0. Reset mid-transfer discards all contents immediately.
- clr at edge: same state as reset, synchronously. rd_en/wr_en in the same cycle are ignored, with no overflow/underflow pulses. dout is zeroed.
- Write accepted iff wr_en && !full. A write while full is dropped and overflow=1 for the next cycle only. A simultaneous rd_en does not make room in the same cycle.
- Read accepted iff rd_en && !empty. A read while empty pulses underflow next cycle, and dout is unchanged. With rd_en && wr_en while empty, the write is accepted and the read is underflow.
- data_count: +1 on accepted write only, -1 on accepted read only, unchanged on both. It counts every word held, including the FWFT output stage. full = (data_count==DEPTH).
- Standard mode (FWFT=0):
  - empty deasserts after the edge that accepts the first write.
  - For a read accepted at edge t, dout carries the word after edge t (1-cycle latency).
  - dout holds between reads.
- FWFT mode (FWFT=1):
  - A word written into an empty FIFO at edge t appears on dout with empty=0 after edge t+1.
  - rd_en with !empty pops. The next word, if any, is on dout after the same edge with empty still 0, giving full throughput. Otherwise empty=1 after that edge.
- All flags are registered and consistent with data_count in the same cycle. almost_* are evaluated against the post-edge count.
- Pointers are ADDRESS_WIDTH bits and wrap modulo DEPTH. No state is lost at wrap. Ordering is strictly first-in, first-out.
- Simultaneous read and write when 0<count<DEPTH: both are accepted and the count is unchanged.
- A non-power-of-two depth is not supported. AFULL_THRESH must satisfy 1..DEPTH and AEMPTY_THRESH 0..DEPTH-1; out-of-range values are rejected by elaboration assertions.

Test Plan:
- Reset and fill: AW=4, DEPTH=16, FWFT=0. Write 0x1..0x10 on 16 consecutive cycles. -> data_count steps 1..16. almost_full rises at count 12. full=1 after the 16th edge. A 17th write (0xAA) gives overflow=1 for 1 cycle, and count stays 16.
- Drain in standard mode: continuing from the fill above, assert rd_en 16 cycles. -> dout = 0x1..0x10, one cycle after each rd_en. almost_empty at count 4. empty after the 16th read. A 17th rd_en gives underflow=1 for 1 cycle, and dout holds 0x10.
- FWFT latency: FWFT=1, empty FIFO, write 0x55 at edge t. -> empty=0 and dout=0x55 after t+1. Then rd_en for 1 cycle -> empty=1 and count=0.
- Streaming and wrap: FWFT=1, with rd_en and wr_en both high for 40 cycles on an incrementing pattern. -> count stays constant, data in order across pointer wrap, no flags.
- Boundary simultaneity: full FIFO with rd_en && wr_en -> read accepted, write rejected, overflow pulse, count 15. Empty FIFO with both -> write accepted, underflow pulse, count 1.
- Flush and async reset: with 9 words held, pulse clr -> count=0 and empty=1 next cycle, later data correct. Assert rst asynchronously mid-burst -> outputs reach reset values without a clk edge.
